// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Picks one ready reservation-station entry per cycle (round-robin), pulses
//   its broadcast_bus[idx].rdy so the station frees the slot, and runs the op
//   through an operand-latch stage (E1) and a compute/result register.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   flush          squash request {valid, front_tag, rear_tag, flush_tag}
//   rs_data        station entries
//   acu_operation  per entry: 1 = comparator op, 0 = ALU op
//   ready          per entry: operands resolved and valid
//   rob_stall      ROB cannot accept a result this cycle
//   broadcast_bus  grant; .rdy one-hot single-cycle pulse, .data always 0
//   res_valid/res_tag/res_data  tagged result presented to the ROB

package alu_issue_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SLL = 3'd1,
        ALU_SRL = 3'd2,
        ALU_SRA = 3'd3,
        ALU_XOR = 3'd4,
        ALU_OR  = 3'd5,
        ALU_AND = 3'd6
    } alu_op_e;

    typedef enum logic [2:0] {
        CMP_BEQ  = 3'd0,
        CMP_BNE  = 3'd1,
        CMP_BLT  = 3'd4,
        CMP_BGE  = 3'd5,
        CMP_BLTU = 3'd6,
        CMP_BGEU = 3'd7
    } cmp_op_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] front_tag;
        logic [3:0] rear_tag;
        logic [3:0] flush_tag;
    } flush_t;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] r1;
        logic [31:0] r2;
        alu_op_e     alu_opcode;
        cmp_op_e     cmp_opcode;
        logic [6:0]  funct7;
        logic        busy_r1;
        logic        busy_r2;
        logic        valid;
    } rs_t;

    typedef struct packed {
        logic        rdy;
        logic [31:0] data;
    } sal_t;
endpackage

module alu_issue_unit
    import alu_issue_pkg::*;
#(
    parameter int unsigned size = 8,
    parameter logic [31:0] mask = 32'd7
) (
    input  logic             clk,
    input  logic             rst,
    input  flush_t           flush,
    input  rs_t              rs_data [size],
    input  logic [size-1:0]  acu_operation,
    input  logic [size-1:0]  ready,
    input  logic             rob_stall,
    output sal_t             broadcast_bus [size],
    output logic             res_valid,
    output logic [3:0]       res_tag,
    output logic [31:0]      res_data
);
    localparam int unsigned IDX_W = (size > 1) ? $clog2(size) : 1;

    typedef struct packed {
        logic        valid;
        logic [3:0]  tag;
        logic [31:0] r1;
        logic [31:0] r2;
        alu_op_e     alu_opcode;
        cmp_op_e     cmp_opcode;
        logic [6:0]  funct7;
        logic        acu;
    } e1_t;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    e1_t              e1_q, e1_d;
    logic             res_valid_q, res_valid_d;
    logic [3:0]       res_tag_q, res_tag_d;
    logic [31:0]      res_data_q, res_data_d;

    logic             stall;
    logic [size-1:0]  cand;
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] probe;
    logic [31:0]      e2_result;
    logic             cmp;
    logic [4:0]       sh;
    logic             e1_kill, res_kill;
    logic             rs_unused;

    // Tag survives a flush when it lies in the live window [front, flush_tag).
    // A rear+1 that equals flush_tag means nothing younger exists: keep all.
    function automatic logic keep_tag(input flush_t f, input logic [3:0] t);
        logic [31:0] rear_next;
        rear_next = (32'(f.rear_tag) + 32'd1) & mask;
        if (rear_next == 32'(f.flush_tag))
            return 1'b1;
        if (f.front_tag <= f.flush_tag)
            return (t >= f.front_tag) && (t < f.flush_tag);
        return (t >= f.front_tag) || (t < f.flush_tag);
    endfunction

    assign stall = rob_stall && res_valid_q;
    assign cand  = ready & {size{~flush.valid}};

    // Round-robin: first candidate at or after rr_ptr, wrapping (size is 2^n).
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        probe     = '0;
        for (int unsigned i = 0; i < size; i++) begin
            probe = rr_ptr_q + IDX_W'(i);
            if (!grant_vld && cand[probe]) begin
                grant_vld = 1'b1;
                grant_idx = probe;
            end
        end
        if (rst || stall)
            grant_vld = 1'b0;
        rr_ptr_d = grant_vld ? grant_idx + IDX_W'(1) : rr_ptr_q;
    end

    always_comb begin
        for (int unsigned i = 0; i < size; i++) begin
            broadcast_bus[i].rdy  = grant_vld && (grant_idx == IDX_W'(i));
            broadcast_bus[i].data = '0;
        end
    end

    // Station bookkeeping fields are not needed once ready[] is asserted.
    always_comb begin
        rs_unused = 1'b0;
        for (int unsigned i = 0; i < size; i++)
            rs_unused = rs_unused ^ rs_data[i].busy_r1 ^ rs_data[i].busy_r2 ^ rs_data[i].valid;
    end

    // E2: combinational execute from E1
    always_comb begin
        sh        = e1_q.r2[4:0];
        cmp       = 1'b0;
        e2_result = '0;
        if (e1_q.acu) begin
            case (e1_q.cmp_opcode)
                CMP_BEQ:  cmp = (e1_q.r1 == e1_q.r2);
                CMP_BNE:  cmp = (e1_q.r1 != e1_q.r2);
                CMP_BLT:  cmp = ($signed(e1_q.r1) <  $signed(e1_q.r2));
                CMP_BGE:  cmp = ($signed(e1_q.r1) >= $signed(e1_q.r2));
                CMP_BLTU: cmp = (e1_q.r1 <  e1_q.r2);
                CMP_BGEU: cmp = (e1_q.r1 >= e1_q.r2);
                default:  cmp = 1'b0;
            endcase
            e2_result = {31'b0, cmp};
        end else begin
            case (e1_q.alu_opcode)
                ALU_ADD: e2_result = e1_q.funct7[5] ? e1_q.r1 - e1_q.r2 : e1_q.r1 + e1_q.r2;
                ALU_SLL: e2_result = e1_q.r1 << sh;
                ALU_SRL: e2_result = e1_q.funct7[5] ? 32'($signed(e1_q.r1) >>> sh) : e1_q.r1 >> sh;
                ALU_SRA: e2_result = 32'($signed(e1_q.r1) >>> sh);
                ALU_XOR: e2_result = e1_q.r1 ^ e1_q.r2;
                ALU_OR:  e2_result = e1_q.r1 | e1_q.r2;
                ALU_AND: e2_result = e1_q.r1 & e1_q.r2;
                default: e2_result = '0;
            endcase
        end
    end

    // Pipeline advance. A squash clears valid even on a held (stalled) stage.
    always_comb begin
        e1_kill  = flush.valid && !keep_tag(flush, e1_q.tag);
        res_kill = flush.valid && !keep_tag(flush, res_tag_q);
        if (stall) begin
            e1_d        = e1_q;
            e1_d.valid  = e1_q.valid && !e1_kill;
            res_valid_d = res_valid_q && !res_kill;
            res_tag_d   = res_tag_q;
            res_data_d  = res_data_q;
        end else begin
            res_valid_d = e1_q.valid && !e1_kill;
            res_tag_d   = e1_q.tag;
            res_data_d  = e2_result;
            e1_d        = '0;
            if (grant_vld) begin
                e1_d.valid      = 1'b1;
                e1_d.tag        = rs_data[grant_idx].tag;
                e1_d.r1         = rs_data[grant_idx].r1;
                e1_d.r2         = rs_data[grant_idx].r2;
                e1_d.alu_opcode = rs_data[grant_idx].alu_opcode;
                e1_d.cmp_opcode = rs_data[grant_idx].cmp_opcode;
                e1_d.funct7     = rs_data[grant_idx].funct7;
                e1_d.acu        = acu_operation[grant_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            e1_q        <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            e1_q        <= e1_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_data_q  <= res_data_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_tag   = res_tag_q;
    assign res_data  = res_data_q;
endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Downstream consumer of the ALU reservation station. Each cycle it picks one ready entry by round-robin and pulses that entry's `broadcast_bus[idx].rdy` so the station frees the slot. It then executes the operation in a two-stage pipeline (operand latch, then compute/result register) and presents a tagged 32-bit result to the ROB. It honours ROB back-pressure and the shared `flush_t` squash.

## Interface
Parameters:
- size, 8, number of reservation-station entries served (power of two)
- mask, 32'd7, ROB tag wrap mask

Ports:
- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- flush  in  flush_t  {valid, front_tag, rear_tag, flush_tag}, squash request
- rs_data  in  rs_t[size]  station entries {tag, r1, r2, alu_opcode, cmp_opcode, funct7, busy_r1, busy_r2, valid}
- acu_operation  in  1[size]  1 = comparator op, 0 = ALU op
- ready  in  size  per-entry operands resolved and valid
- rob_stall  in  1  ROB cannot accept a result this cycle
- broadcast_bus  out  sal_t[size]  grant; `.rdy` is a one-hot, single-cycle pulse, `.data` = 0
- res_valid  out  1  result presented to ROB
- res_tag  out  4  ROB tag of the result
- res_data  out  32  result value

## Operation
- Stage S (comb.): the candidate set is `ready & ~{flush.valid}`. No grant is made while stalled (stall = `rob_stall && res_valid`).
- Arbitration: round-robin. Search starts at `rr_ptr`, wraps modulo size, and picks the first set bit. `rr_ptr` <= granted idx + 1 (mod size) on each grant; otherwise unchanged.
- Grant: `broadcast_bus[g].rdy` = 1 in the same cycle. All other entries are 0. The station clears entry g at the edge that ends that cycle, so the same entry is never granted twice.
- E1 register (valid, tag, r1, r2, alu_opcode, cmp_opcode, funct7, acu): loaded on grant, holds on stall, otherwise cleared to valid = 0.
- E2 compute, combinational from E1:
  - acu = 0:
    - add: r1 + r2, or r1 - r2 when funct7[5]
    - sll: r1 << r2[4:0]
    - srl: logical shift; sra when funct7[5]
    - sra: arithmetic shift
    - xor, or, and: bitwise
  - acu = 1: {31'b0, cmp}, where cmp is eq / ne / lt / ge (signed) or ltu / geu (unsigned) per cmp_opcode.
  - All arithmetic is 32-bit modulo with no overflow flag.
- Result register (res_valid, res_tag, res_data): loads from E2 when not stalled, holds while stalled.
- Flush keep rule for tag t:
  - If ((rear_tag + 1) & mask) == flush_tag, keep all.
  - Else if front_tag <= flush_tag, keep when front_tag <= t < flush_tag.
  - Else keep when t >= front_tag || t < flush_tag.
- Flush actions when flush.valid is high:
  - No grant that cycle.
  - E1 and the result register are each cleared to valid = 0 if their tag fails the keep rule.
  - A stall does not protect a squashed entry.
  - `rr_ptr` is unchanged.

## Timing
- Reset values:
  - broadcast_bus all rdy = 0, data = 0
  - res_valid = 0, res_tag = 0, res_data = 0
  - E1 valid = 0
  - rr_ptr = 0
- Reset has priority over flush and stall and applies mid-pipeline; in-flight ops are dropped.
- Latency:
  - Entry ready in cycle N → grant pulse in cycle N.
  - Operands in E1 in cycle N+1.
  - res_valid in cycle N+2.
- Throughput: one result per cycle when unstalled.
- Stall:
  - `rob_stall` only stalls when res_valid = 1.
  - While stalled, the result register and E1 hold, and there are no grants.
  - Bubbles collapse: if res_valid = 0, the pipeline advances regardless of rob_stall.
- Handshake: the ROB consumes the result in any cycle with `res_valid && !rob_stall`.
- Simultaneous flush and stall: the flush squash is applied. If the result register is squashed, the stall ends because res_valid becomes 0.
- Empty: with ready = 0 there are no grants, E1 drains and res_valid falls two cycles later.

## Test plan
- Single add: entry 3 ready, r1 = 5, r2 = 7, alu_add, funct7 = 0, tag 2. Expect broadcast_bus[3].rdy in cycle N, then res_valid/res_tag = 2/res_data = 12 at N+2; sub with funct7 = 0x20 gives 0xFFFFFFFE.
- Round-robin: entries 0, 1, 5 ready continuously with rr_ptr = 0. Expect grants 0, 1, 5, then the wrap-around grant order 0…; no entry granted in consecutive cycles once it is cleared.
- Compare: acu = 1, cmp_blt, r1 = 0xFFFFFFFF, r2 = 1 → res_data = 1; cmp_bltu with the same operands → 0.
- Stall: results A and B in flight, rob_stall held 3 cycles. Expect A held on the outputs, no grants, B kept in E1; release → A, then B on consecutive cycles.
- Flush: front = 1, flush_tag = 3, rear = 5, with E1 tag 4 and result register tag 2. Expect E1 squashed, tag 2 kept, no grant in the flush cycle.
- Reset mid-operation: assert rst with two ops in flight and rob_stall = 1. Next cycle: res_valid = 0, all rdy = 0, and the first grant after reset goes to the lowest ready index.
